// File: rtl/shreg_deser.sv
// Serial-to-parallel receiver: rebuilds WIDTH-bit words from a valid-qualified bit stream
// and holds each word in a one-entry valid/ready register. Optional parity: SHREG_DESER_PARITY_CHK_EN.
module shreg_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             ser_in,
  input  logic             ser_valid,
  input  logic             dir,
  input  logic             abort,
  output logic [WIDTH-1:0] data_out,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             overrun,
  output logic             parity_err
);

`ifdef SHREG_DESER_PARITY_CHK_EN
  localparam int FRAME = WIDTH + 1;
`else
  localparam int FRAME = WIDTH;
`endif
  localparam int CW = $clog2(FRAME + 1);
  localparam logic [CW-1:0] LAST = CW'(FRAME - 1);

  logic [CW-1:0]    cnt_reg;
  logic [WIDTH-1:0] shbuf_reg;
  logic             dir_l_reg;

  logic             dir_eff;
  logic [WIDTH-1:0] shifted;
  logic             last_bit;
  logic             capture;
  logic             complete;
  logic [WIDTH-1:0] word;
  logic             perr;

`ifdef SHREG_DESER_PARITY_CHK_EN
  logic par_reg;
  logic data_bit;
`endif

  // The first bit of a word shifts with the live dir, since dir_l is only loaded on that edge.
  always_comb begin
    dir_eff  = (cnt_reg == '0) ? dir : dir_l_reg;
    shifted  = dir_eff ? {shbuf_reg[WIDTH-2:0], ser_in} : {ser_in, shbuf_reg[WIDTH-1:1]};
    last_bit = (cnt_reg == LAST);
    capture  = ser_valid && !abort;
    complete = capture && last_bit;
`ifdef SHREG_DESER_PARITY_CHK_EN
    data_bit = (cnt_reg < CW'(WIDTH));
    word     = shbuf_reg;
    perr     = par_reg ^ ser_in;
`else
    word     = shifted;
    perr     = 1'b0;
`endif
  end

  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      cnt_reg    <= '0;
      shbuf_reg  <= '0;
      dir_l_reg  <= 1'b0;
      data_out   <= '0;
      out_valid  <= 1'b0;
      overrun    <= 1'b0;
      parity_err <= 1'b0;
`ifdef SHREG_DESER_PARITY_CHK_EN
      par_reg    <= 1'b0;
`endif
    end else begin
      overrun    <= 1'b0;
      parity_err <= 1'b0;

      if (abort) begin
        cnt_reg   <= '0;
        shbuf_reg <= '0;
`ifdef SHREG_DESER_PARITY_CHK_EN
        par_reg   <= 1'b0;
`endif
      end else if (ser_valid) begin
        if (cnt_reg == '0)
          dir_l_reg <= dir;
        if (last_bit) begin
          cnt_reg   <= '0;
          shbuf_reg <= '0;
`ifdef SHREG_DESER_PARITY_CHK_EN
          par_reg   <= 1'b0;
`endif
        end else begin
          cnt_reg <= cnt_reg + 1'b1;
`ifdef SHREG_DESER_PARITY_CHK_EN
          if (data_bit) begin
            shbuf_reg <= shifted;
            par_reg   <= par_reg ^ ser_in;
          end
`else
          shbuf_reg <= shifted;
`endif
        end
      end

      // A completing word wins the register if it is empty or being drained this edge.
      if (complete) begin
        if (!out_valid || out_ready) begin
          data_out   <= word;
          out_valid  <= 1'b1;
          parity_err <= perr;
        end else begin
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_shreg_deser.sv
// Directed self-checking bench for shreg_deser (WIDTH=4); parity scenario runs when
// SHREG_DESER_PARITY_CHK_EN is defined.
module tb_shreg_deser;
  logic       clk;
  logic       clr;
  logic       ser_in;
  logic       ser_valid;
  logic       dir;
  logic       abort;
  logic [3:0] data_out;
  logic       out_valid;
  logic       out_ready;
  logic       overrun;
  logic       parity_err;

  int total = 0;
  int bad = 0;

  shreg_deser #(.WIDTH(4)) dut (
    .clk(clk), .clr(clr), .ser_in(ser_in), .ser_valid(ser_valid), .dir(dir),
    .abort(abort), .data_out(data_out), .out_valid(out_valid), .out_ready(out_ready),
    .overrun(overrun), .parity_err(parity_err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic b);
    ser_valid = 1;
    ser_in = b;
    tick();
    ser_valid = 0;
  endtask

  // seq[3] is sent first; in the parity build an even-parity bit is appended.
  task automatic send_word(input logic [3:0] seq, input logic d);
    dir = d;
    for (int i = 3; i >= 0; i--) send_bit(seq[i]);
`ifdef SHREG_DESER_PARITY_CHK_EN
    send_bit(^seq);
`endif
    $display("word sent bits=%b dir=%0d -> data_out=%b out_valid=%0d overrun=%0d",
             seq, d, data_out, out_valid, overrun);
  endtask

  task automatic consume();
    out_ready = 1;
    tick();
    out_ready = 0;
  endtask

  task automatic test_reset();
    clr = 1;
    tick();
    tick();
    total++; if (data_out !== 4'b0000) begin bad++; $display("FAIL reset_data got=%b want=0000", data_out); end
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%b want=0", out_valid); end
    total++; if (overrun !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL reset_pulses got=%b%b want=00", overrun, parity_err); end
    clr = 0;
    tick();
    total++; if (out_valid !== 1'b0 || data_out !== 4'b0000) begin bad++; $display("FAIL post_reset got valid=%b data=%b want 0/0000", out_valid, data_out); end
    $display("reset done");
  endtask

  task automatic test_assemble();
    out_ready = 0;
    dir = 0;
    send_bit(0); send_bit(0); send_bit(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL early_valid got=%b want=0", out_valid); end
    send_bit(1);
`ifdef SHREG_DESER_PARITY_CHK_EN
    send_bit(0);
`endif
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL lsb_valid got=%b want=1", out_valid); end
    total++; if (data_out !== 4'b1100) begin bad++; $display("FAIL lsb_data got=%b want=1100", data_out); end
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL lsb_parity got=%b want=0", parity_err); end
    consume();
    total++; if (out_valid !== 1'b0 || data_out !== 4'b1100) begin bad++; $display("FAIL drain got valid=%b data=%b want 0/1100", out_valid, data_out); end
    send_word(4'b0011, 1);
    total++; if (data_out !== 4'b0011 || out_valid !== 1'b1) begin bad++; $display("FAIL msb_data got=%b valid=%b want=0011/1", data_out, out_valid); end
    consume();
    // dir flips after the first bit: word must still assemble MSB-first
    dir = 1; send_bit(0);
    dir = 0; send_bit(0); send_bit(1); send_bit(1);
`ifdef SHREG_DESER_PARITY_CHK_EN
    send_bit(0);
`endif
    total++; if (data_out !== 4'b0011) begin bad++; $display("FAIL dir_latch got=%b want=0011", data_out); end
    consume();
  endtask

  task automatic test_overrun();
    out_ready = 0;
    send_word(4'b0011, 0);
    send_word(4'b1010, 0);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_pulse got=%b want=1", overrun); end
    total++; if (data_out !== 4'b1100 || out_valid !== 1'b1) begin bad++; $display("FAIL overrun_hold got=%b valid=%b want=1100/1", data_out, out_valid); end
    tick();
    total++; if (overrun !== 1'b0 || data_out !== 4'b1100) begin bad++; $display("FAIL overrun_width got ovr=%b data=%b want 0/1100", overrun, data_out); end
    dir = 0;
    send_bit(1); send_bit(0); send_bit(1);
`ifdef SHREG_DESER_PARITY_CHK_EN
    send_bit(0);
    out_ready = 1;
    send_bit(0);
`else
    out_ready = 1;
    send_bit(0);
`endif
    out_ready = 0;
    total++; if (data_out !== 4'b0101 || out_valid !== 1'b1 || overrun !== 1'b0) begin bad++; $display("FAIL replace got data=%b valid=%b ovr=%b want 0101/1/0", data_out, out_valid, overrun); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL replace_drain got=%b want=0", out_valid); end
  endtask

  task automatic test_abort();
    dir = 0;
    send_bit(1); send_bit(1);
    abort = 1; ser_valid = 1; ser_in = 1;
    tick();
    abort = 0; ser_valid = 0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_stray got=%b want=0", out_valid); end
    send_word(4'b1001, 0);
    total++; if (data_out !== 4'b1001 || out_valid !== 1'b1) begin bad++; $display("FAIL abort_word got=%b valid=%b want=1001/1", data_out, out_valid); end
    consume();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL abort_extra got=%b want=0", out_valid); end
    // bits 1,1,0,1 with 3 idle cycles in between
    send_bit(1); tick(); tick(); tick();
    send_bit(1); tick(); tick(); tick();
    send_bit(0); tick(); tick(); tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL gap_early got=%b want=0", out_valid); end
    send_bit(1);
`ifdef SHREG_DESER_PARITY_CHK_EN
    send_bit(1);
`endif
    total++; if (data_out !== 4'b1011 || out_valid !== 1'b1) begin bad++; $display("FAIL gap_word got=%b valid=%b want=1011/1", data_out, out_valid); end
    consume();
  endtask

  task automatic test_clear();
    send_word(4'b0110, 0);
    total++; if (data_out !== 4'b0110 || out_valid !== 1'b1) begin bad++; $display("FAIL clr_pre got=%b valid=%b want=0110/1", data_out, out_valid); end
    send_bit(1); send_bit(0); send_bit(1);
    #2 clr = 1;
    #1;
    total++; if (data_out !== 4'b0000 || out_valid !== 1'b0 || overrun !== 1'b0 || parity_err !== 1'b0) begin bad++; $display("FAIL clr_async got data=%b valid=%b ovr=%b perr=%b want all 0", data_out, out_valid, overrun, parity_err); end
    tick();
    clr = 0;
    dir = 0;
    send_bit(1); send_bit(1); send_bit(1);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL clr_count got=%b want=0", out_valid); end
    send_bit(1);
`ifdef SHREG_DESER_PARITY_CHK_EN
    send_bit(0);
`endif
    total++; if (data_out !== 4'b1111 || out_valid !== 1'b1) begin bad++; $display("FAIL clr_after got=%b valid=%b want=1111/1", data_out, out_valid); end
    consume();
  endtask

`ifdef SHREG_DESER_PARITY_CHK_EN
  task automatic test_parity();
    dir = 0;
    send_bit(1); send_bit(1); send_bit(0); send_bit(0);
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL par_wait got=%b want=0", out_valid); end
    send_bit(0);
    total++; if (data_out !== 4'b0011 || parity_err !== 1'b0) begin bad++; $display("FAIL par_ok got=%b perr=%b want=0011/0", data_out, parity_err); end
    consume();
    send_bit(1); send_bit(0); send_bit(0); send_bit(0); send_bit(0);
    total++; if (data_out !== 4'b0001 || out_valid !== 1'b1 || parity_err !== 1'b1) begin bad++; $display("FAIL par_err got=%b valid=%b perr=%b want=0001/1/1", data_out, out_valid, parity_err); end
    tick();
    total++; if (parity_err !== 1'b0) begin bad++; $display("FAIL par_width got=%b want=0", parity_err); end
    consume();
  endtask
`endif

  initial begin
    clr = 0; ser_in = 0; ser_valid = 0; dir = 0; abort = 0; out_ready = 0;
    #2;
    test_reset();
    test_assemble();
    test_overrun();
    test_abort();
    test_clear();
`ifdef SHREG_DESER_PARITY_CHK_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
